// File: rtl/wb_reg_slave.sv
// Wishbone classic register slave: ID word, write counter and scratch words,
// with a fixed, parameterised response latency.
module wb_reg_slave #(
  parameter int unsigned G_WAIT_STATES = 1,
  parameter int unsigned G_NUM_REGS    = 16,
  parameter logic [31:0] G_ID          = 32'hB0B0_CAFE
) (
  input  logic        clk_sys_i,
  input  logic        rst_n_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [5:0]  idx_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q;
  logic        ack_q;
  logic        err_q;
  logic [31:0] rdat_q;
  logic [31:0] wrcnt_q;
  logic [31:0] regs_q [G_NUM_REGS];

  logic        req;
  logic        mapped;
  logic [31:0] rd_word;
  logic [31:0] wmask;
  logic        unused_adr;

  assign req        = wb_cyc_i & wb_stb_i;
  assign mapped     = ({1'b0, idx_q} < 7'(G_NUM_REGS));
  assign wmask      = {{8{sel_q[3]}}, {8{sel_q[2]}}, {8{sel_q[1]}}, {8{sel_q[0]}}};
  assign unused_adr = ^{wb_adr_i[31:8], wb_adr_i[1:0]};

  always_comb begin
    rd_word = '0;
    if (idx_q == 6'd0) begin
      rd_word = G_ID;
    end else if (idx_q == 6'd1) begin
      rd_word = wrcnt_q;
    end else begin
      for (int unsigned i = 2; i < G_NUM_REGS; i++) begin
        if (idx_q == 6'(i)) rd_word = regs_q[i];
      end
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
      wrcnt_q <= '0;
      for (int unsigned i = 0; i < G_NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      rdat_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            idx_q <= wb_adr_i[7:2];
            we_q  <= wb_we_i;
            sel_q <= wb_sel_i;
            dat_q <= wb_dat_i;
            if (G_WAIT_STATES == 0) begin
              state_q <= StResp;
            end else begin
              cnt_q   <= 4'(G_WAIT_STATES);
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          // Only cyc aborts; stb may drop once the request is captured.
          if (!wb_cyc_i) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_q <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
          if (!mapped) begin
            err_q <= 1'b1;
          end else begin
            ack_q <= 1'b1;
            if (we_q) begin
              wrcnt_q <= wrcnt_q + 32'd1;
              for (int unsigned i = 2; i < G_NUM_REGS; i++) begin
                if (idx_q == 6'(i)) regs_q[i] <= (regs_q[i] & ~wmask) | (dat_q & wmask);
              end
            end else begin
              rdat_q <= rd_word;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wb_dat_o = rdat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;

endmodule
